pdm_tx_dac: RTL

- PCM-to-PDM transmitter peripheral for the TinyQV bus; the output-direction counterpart of the PDM microphone block.
- CPU writes 16-bit signed PCM samples into a 4-deep FIFO.
- A second-order delta-sigma modulator turns each sample into OSR one-bit PDM symbols on pdm_dat_o, with a generated pdm_clk_o, to drive a PDM amplifier or RC-filtered speaker.
- Interrupt requests more samples.

---
 rtl/pdm_tx_dac_if.sv | 11 +
 rtl/pdm_tx_dac.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pdm_tx_dac_if.sv
// pdm_tx_dac_if: TinyQV peripheral register bus between the CPU (master) and the PDM transmitter (slave).
interface pdm_tx_dac_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    modport master (output address, data_in, data_write_n, data_read_n, input data_out, data_ready);
    modport slave (input address, data_in, data_write_n, data_read_n, output data_out, data_ready);
endinterface

// File: rtl/pdm_tx_dac.sv
// pdm_tx_dac: PCM-to-PDM transmitter with a sample FIFO and a 2nd-order delta-sigma modulator.
// Define PDM_TX_DITHER_EN to add a small LFSR dither term to the modulator input.
module pdm_tx_dac #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] CLKDIV_RESET = 8'd20,
    parameter logic [7:0] OSR_RESET    = 8'd63
) (
    input  logic        clk,
    input  logic        rst,
    pdm_tx_dac_if.slave bus,
    output logic        pdm_clk_o,
    output logic        pdm_dat_o,
    output logic        user_interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic          en, ie, flush, underrun, overflow;
    logic [7:0]    clkdiv, osr, phase, bitcnt, peff;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [15:0]   cur;
    logic [19:0]   i1, i1_n;
    logic [23:0]   i2, i2_n;
    logic [21:0]   x, s1;
    logic [25:0]   s2;
    logic          wr, tick, pop, do_pop, push, do_push, empty, full;
    logic          unused_ok;

    assign wr      = bus.data_write_n != 2'b11;
    assign peff    = clkdiv < 8'd2 ? 8'd2 : clkdiv;
    assign tick    = en && phase == 8'd0;
    assign pop     = tick && bitcnt == osr;
    assign empty   = level == '0;
    assign full    = level == LW'(FIFO_DEPTH);
    assign do_pop  = pop && !empty && !flush;
    assign push    = wr && bus.address == 6'h08;
    assign do_push = push && !flush && (!full || do_pop);

`ifdef PDM_TX_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) lfsr <= 16'hACE1;
        else if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign x = {{6{cur[15]}}, cur} + {{18{lfsr[3]}}, lfsr[3:0]};
`else
    assign x = {{6{cur[15]}}, cur};
`endif

    // Feedback is +32767 / -32768 chosen by the previous output bit; integrators saturate instead of wrapping.
    assign s1   = {{2{i1[19]}}, i1} + x - (pdm_dat_o ? 22'h007FFF : 22'h3F8000);
    assign s2   = {{2{i2[23]}}, i2} + {{6{i1[19]}}, i1} - (pdm_dat_o ? 26'h0007FFF : 26'h3FF8000);
    assign i1_n = s1[21:19] == 3'b000 || s1[21:19] == 3'b111 ? s1[19:0] : {s1[21], {19{~s1[21]}}};
    assign i2_n = s2[25:23] == 3'b000 || s2[25:23] == 3'b111 ? s2[23:0] : {s2[25], {23{~s2[25]}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en             <= 1'b0;
            ie             <= 1'b0;
            flush          <= 1'b0;
            underrun       <= 1'b0;
            overflow       <= 1'b0;
            clkdiv         <= CLKDIV_RESET;
            osr            <= OSR_RESET;
            phase          <= 8'd0;
            bitcnt         <= 8'd0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            cur            <= 16'd0;
            i1             <= 20'd0;
            i2             <= 24'd0;
            pdm_clk_o      <= 1'b0;
            pdm_dat_o      <= 1'b0;
            user_interrupt <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 16'd0;
        end else begin
            flush <= 1'b0;
            if (wr && bus.address == 6'h00) begin
                en    <= bus.data_in[0];
                flush <= bus.data_in[1];
                ie    <= bus.data_in[2];
            end
            if (wr && bus.address == 6'h04) clkdiv <= bus.data_in[7:0];
            if (wr && bus.address == 6'h10) osr <= bus.data_in[7:0];
            if (wr && bus.address == 6'h0C && bus.data_in[6]) underrun <= 1'b0;
            if (wr && bus.address == 6'h0C && bus.data_in[7]) overflow <= 1'b0;
            if (pop && empty && !flush) underrun <= 1'b1;
            if (push && !flush && full && !do_pop) overflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= bus.data_in[15:0];
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (do_pop) rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(do_push) - LW'(do_pop);
            end
            if (!en) begin
                phase     <= 8'd0;
                bitcnt    <= 8'd0;
                i1        <= 20'd0;
                i2        <= 24'd0;
                cur       <= 16'd0;
                pdm_clk_o <= 1'b0;
                pdm_dat_o <= 1'b0;
            end else begin
                // Registering the divided clock lines its rising edge up with the tick that updates pdm_dat_o.
                phase     <= phase >= peff - 8'd1 ? 8'd0 : phase + 8'd1;
                pdm_clk_o <= phase < {1'b0, peff[7:1]};
                if (tick) begin
                    i1        <= i1_n;
                    i2        <= i2_n;
                    pdm_dat_o <= ~i2_n[23];
                    bitcnt    <= bitcnt == osr ? 8'd0 : bitcnt + 8'd1;
                end
                if (do_pop) cur <= mem[rd_ptr];
            end
            user_interrupt <= ie && (level < LW'(2) || underrun);
        end
    end

    assign bus.data_out = bus.address == 6'h00 ? {29'h0, ie, 1'b0, en} :
                          bus.address == 6'h04 ? {24'h0, clkdiv} :
                          bus.address == 6'h0C ? {24'h0, overflow, underrun, full, empty, 1'b0, 3'(level)} :
                          bus.address == 6'h10 ? {24'h0, osr} : 32'h0;
    assign bus.data_ready = 1'b1;
    assign unused_ok = &{1'b0, bus.data_read_n, bus.data_in[31:16]};
endmodule
